// File: rtl/ppi_pkg.sv
// Shared types and helpers for the polyphase interpolator output adapter.
package ppi_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      CHECK    = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

   typedef struct packed {
      logic        sat;
      logic [63:0] val;
   } rs_t;

   // ceil(log2(n)), 0 for n <= 1
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Round-half-up by dropping fd LSBs, then clamp to a signed ow-bit range.
   // din is the sign-extended sample; the 65-bit sum cannot overflow.
   function automatic rs_t round_sat(input logic signed [63:0] din,
                                     input int fd, input int ow);
      logic signed [64:0] sum;
      logic signed [64:0] shr;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      rs_t                r;
      sum   = {din[63], din} + (65'sd1 <<< (fd - 1));
      shr   = sum >>> fd;
      hi    = (65'sd1 <<< (ow - 1)) - 65'sd1;
      lo    = -(65'sd1 <<< (ow - 1));
      r.sat = 1'b0;
      r.val = shr[63:0];
      if (shr > hi) begin
         r.val = hi[63:0];
         r.sat = 1'b1;
      end else if (shr < lo) begin
         r.val = lo[63:0];
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ppi_out_adapter_sync_fifo.sv
// Single-clock FIFO; head is read straight from the storage flops.
// A push into a full FIFO is accepted only together with a pop.
module sync_fifo import ppi_pkg::*; #(
   parameter int gp_width = 8,
   parameter int gp_depth = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [gp_width-1:0]       din,
   output logic [gp_width-1:0]       dout,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(gp_depth):0]  count
);

   localparam int AW = clog2(gp_depth);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(gp_depth);

   logic [gp_width-1:0] mem [gp_depth];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // storage, pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < gp_depth; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ppi_out_adapter.sv
// Output adapter for the polyphase interpolator: phase tagging, round/saturate,
// output FIFO with valid/ready, phase-lock detection and sticky error flags.
//
// Lock FSM:
//   state    | meaning
//   UNLOCKED | no sclk edge seen since reset
//   CHECK    | edge seen, waiting for a period of exactly gp_interpolation_factor samples
//   LOCKED   | last period matched; o_lock high
module ppi_out_adapter import ppi_pkg::*; #(
   parameter int gp_idata_width          = 26,
   parameter int gp_odata_width          = 16,
   parameter int gp_frac_drop            = 10,
   parameter int gp_interpolation_factor = 30,
   parameter int gp_fifo_depth           = 8
) (
   input  logic                                     i_clk,
   input  logic                                     i_rst,
   input  logic                                     i_ena,
   input  logic [gp_idata_width-1:0]                i_data,
   input  logic                                     i_sclk,
   input  logic                                     i_clr_flags,
   output logic [gp_odata_width-1:0]                o_data,
   output logic [clog2(gp_interpolation_factor)-1:0] o_phase,
   output logic                                     o_valid,
   input  logic                                     i_ready,
   output logic [clog2(gp_fifo_depth):0]            o_fill,
   output logic                                     o_lock,
   output logic                                     o_sat,
   output logic                                     o_ovf
);

   localparam int PW = clog2(gp_interpolation_factor);
   localparam int CW = clog2(gp_interpolation_factor + 1) + 1;
   localparam int FW = gp_odata_width + PW;
   localparam logic [PW-1:0] PH_LAST  = PW'(gp_interpolation_factor - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(gp_interpolation_factor);

   logic                      sclk_d;
   logic                      sclk_edge;
   logic                      edge_pend;
   logic                      eff_edge;
   logic [PW-1:0]             ph_next;
   logic [PW-1:0]             tag;

   logic                      s1_valid;
   logic                      s1_edge;
   logic [gp_idata_width-1:0] s1_data;
   logic [PW-1:0]             s1_phase;
   logic signed [63:0]        din64;
   rs_t                       rs;
   logic                      unused_rs_hi;

   logic                      s2_valid;
   logic [gp_odata_width-1:0] s2_data;
   logic [PW-1:0]             s2_phase;

   logic [FW-1:0]             fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;

   lock_state_t               state;
   lock_state_t               state_nx;
   logic [CW-1:0]             cnt;
   logic                      lock_eval;

   // an edge seen on a cycle without i_ena is carried to the next sample
   assign sclk_edge = i_sclk & ~sclk_d;
   assign eff_edge  = sclk_edge | edge_pend;

   // tag for the sample accepted this cycle
   always_comb begin
      tag = ph_next;
      if (eff_edge) tag = '0;
   end

   // stage 1: capture sample, phase tag and edge marker
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_d    <= i_sclk;
         edge_pend <= 1'b0;
         ph_next   <= '0;
         s1_valid  <= 1'b0;
         s1_edge   <= 1'b0;
         s1_data   <= '0;
         s1_phase  <= '0;
      end else begin
         sclk_d   <= i_sclk;
         s1_valid <= i_ena;
         if (i_ena) begin
            s1_data   <= i_data;
            s1_phase  <= tag;
            s1_edge   <= eff_edge;
            ph_next   <= (tag == PH_LAST) ? '0 : tag + 1'b1;
            edge_pend <= 1'b0;
         end else if (sclk_edge) begin
            edge_pend <= 1'b1;
         end
      end
   end

   assign din64 = {{(64-gp_idata_width){s1_data[gp_idata_width-1]}}, s1_data};

   // combinational round/saturate of the stage-1 sample
   always_comb begin
      rs = round_sat(din64, gp_frac_drop, gp_odata_width);
   end

   assign unused_rs_hi = ^rs.val[63:gp_odata_width];

   // stage 2: register rounded sample; it is pushed into the FIFO next edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_phase <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data  <= rs.val[gp_odata_width-1:0];
            s2_phase <= s1_phase;
         end
      end
   end

   sync_fifo #(
      .gp_width (FW),
      .gp_depth (gp_fifo_depth)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (s2_valid),
      .pop   (i_ready),
      .din   ({s2_data, s2_phase}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (o_fill)
   );

   assign o_data  = fifo_dout[FW-1:PW];
   assign o_phase = fifo_dout[PW-1:0];
   assign o_valid = ~fifo_empty;

   // sticky flags; a set in the same cycle as a clear wins
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_sat <= 1'b0;
         o_ovf <= 1'b0;
      end else begin
         o_sat <= (o_sat & ~i_clr_flags) | (s1_valid & rs.sat);
         o_ovf <= (o_ovf & ~i_clr_flags) | (s2_valid & fifo_full & ~i_ready);
      end
   end

   assign lock_eval = s1_valid & s1_edge;

   // lock FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= UNLOCKED;
      else       state <= state_nx;
   end

   // samples per period; the edge sample starts the new period
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (s1_valid) begin
         if (lock_eval)     cnt <= CW'(1);
         else if (cnt != '1) cnt <= cnt + 1'b1;
      end
   end

   // lock FSM next state, evaluated on edge samples only
   always_comb begin
      state_nx = state;
      if (lock_eval) begin
         case (state)
            UNLOCKED: state_nx = CHECK;
            CHECK:    state_nx = (cnt == CNT_FULL) ? LOCKED : CHECK;
            LOCKED:   state_nx = (cnt == CNT_FULL) ? LOCKED : CHECK;
            default:  state_nx = UNLOCKED;
         endcase
      end
   end

   assign o_lock = (state == LOCKED);

endmodule

// File: tb/tb_ppi_out_adapter.sv
// Bench for ppi_out_adapter: scoreboard of expected (data, phase) pairs plus
// directed checks on flags, fill level and lock.
module tb_ppi_out_adapter;

   logic        clk;
   logic        i_rst;
   logic        i_ena;
   logic [25:0] i_data;
   logic        i_sclk;
   logic        i_clr_flags;
   logic [15:0] o_data;
   logic [4:0]  o_phase;
   logic        o_valid;
   logic        i_ready;
   logic [3:0]  o_fill;
   logic        o_lock;
   logic        o_sat;
   logic        o_ovf;

   int          checks = 0;
   int          errors = 0;

   logic [20:0] exp_q[$];
   int          ph_next;
   bit          pend;
   logic        sclk_prev;
   logic        sclk_lvl;
   logic        clr_lvl;

   ppi_out_adapter dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_ena       (i_ena),
      .i_data      (i_data),
      .i_sclk      (i_sclk),
      .i_clr_flags (i_clr_flags),
      .o_data      (o_data),
      .o_phase     (o_phase),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_fill      (o_fill),
      .o_lock      (o_lock),
      .o_sat       (o_sat),
      .o_ovf       (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_round(input int d);
      longint s;
      s = longint'(d) + 64'sd512;
      s = s >>> 10;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   // one clock: drive inputs, check/pop scoreboard head, update the model
   task automatic cycle(input logic ena, input int d, input logic rdy, input logic keep);
      logic        sedge;
      int          tg;
      logic [20:0] h;
      i_ena       = ena;
      i_data      = 26'(d);
      i_sclk      = sclk_lvl;
      i_ready     = rdy;
      i_clr_flags = clr_lvl;
      if (o_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got data=%0d phase=%0d, want no output", $signed(o_data), o_phase);
         end else begin
            h = exp_q[0];
            if ({o_data, o_phase} !== h) begin
               errors++;
               $display("FAIL sb_head: got data=%0d phase=%0d, want data=%0d phase=%0d",
                        $signed(o_data), o_phase, $signed(h[20:5]), h[4:0]);
            end
            if (rdy) void'(exp_q.pop_front());
         end
      end
      sedge     = sclk_lvl & ~sclk_prev;
      sclk_prev = sclk_lvl;
      if (ena) begin
         tg      = (sedge || pend) ? 0 : ph_next;
         pend    = 1'b0;
         ph_next = (tg == 29) ? 0 : tg + 1;
         if (keep) exp_q.push_back({exp_round(d), 5'(tg)});
      end else if (sedge) begin
         pend = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_ena       = 1'b0;
      i_ready     = 1'b0;
      i_clr_flags = 1'b0;
      i_sclk      = sclk_lvl;
      @(posedge clk);
      #1;
      i_rst     = 1'b0;
      exp_q.delete();
      ph_next   = 0;
      pend      = 1'b0;
      sclk_prev = sclk_lvl;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0 && o_valid !== 1'b1) break;
         cycle(1'b0, 0, 1'b1, 1'b0);
      end
      checks++;
      if (exp_q.size() != 0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: got %0d pending, o_valid=%b, want 0 pending, o_valid=0", exp_q.size(), o_valid);
      end
   endtask

   task automatic test_reset();
      sclk_lvl = 1'b0;
      clr_lvl  = 1'b0;
      do_reset();
      checks += 7;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, want 0", o_valid); end
      if (o_fill  !== 4'd0) begin errors++; $display("FAIL rst_fill: got %0d, want 0", o_fill); end
      if (o_lock  !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b, want 0", o_lock); end
      if (o_sat   !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b, want 0", o_sat); end
      if (o_ovf   !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, want 0", o_ovf); end
      if (o_data  !== 16'd0) begin errors++; $display("FAIL rst_data: got %0d, want 0", o_data); end
      if (o_phase !== 5'd0) begin errors++; $display("FAIL rst_phase: got %0d, want 0", o_phase); end
   endtask

   task automatic test_rounding();
      int vals[4] = '{511, 512, -512, -513};
      sclk_lvl = 1'b0;
      do_reset();
      sclk_lvl = 1'b1;
      foreach (vals[i]) cycle(1'b1, vals[i], 1'b1, 1'b1);
      drain();
      checks += 2;
      if (o_sat !== 1'b0) begin errors++; $display("FAIL round_sat: got %b, want 0", o_sat); end
      if (o_ovf !== 1'b0) begin errors++; $display("FAIL round_ovf: got %b, want 0", o_ovf); end
   endtask

   task automatic test_saturation();
      sclk_lvl = 1'b0;
      do_reset();
      sclk_lvl = 1'b1;
      cycle(1'b1, 33554431, 1'b1, 1'b1);
      drain();
      checks++;
      if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_set: got %b, want 1", o_sat); end
      clr_lvl = 1'b1;
      cycle(1'b0, 0, 1'b1, 1'b0);
      clr_lvl = 1'b0;
      checks++;
      if (o_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b, want 0", o_sat); end
      cycle(1'b1, -33554432, 1'b1, 1'b1);
      drain();
      checks++;
      if (o_sat !== 1'b0) begin errors++; $display("FAIL sat_min_noclamp: got %b, want 0", o_sat); end
      // clear lands in the same cycle the clamp is detected
      cycle(1'b1, 33554431, 1'b1, 1'b1);
      clr_lvl = 1'b1;
      cycle(1'b0, 0, 1'b1, 1'b0);
      clr_lvl = 1'b0;
      checks++;
      if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b, want 1", o_sat); end
      drain();
   endtask

   task automatic run_period(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         sclk_lvl = (i < n / 2);
         cycle(1'b1, int'($urandom_range(0, 2000000)) - 1000000, rdy, 1'b1);
      end
   endtask

   task automatic test_lock();
      int   per[5]      = '{30, 30, 29, 30, 30};
      logic exp_lock[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      sclk_lvl = 1'b0;
      do_reset();
      foreach (per[p]) begin
         run_period(per[p], 1'b1);
         checks++;
         if (o_lock !== exp_lock[p]) begin
            errors++;
            $display("FAIL lock_period%0d: got %b, want %b", p, o_lock, exp_lock[p]);
         end
      end
      drain();
   endtask

   task automatic test_pending_edge();
      sclk_lvl = 1'b0;
      do_reset();
      sclk_lvl = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1024 * i, 1'b1, 1'b1);
      sclk_lvl = 1'b0;
      cycle(1'b0, 0, 1'b1, 1'b0);
      sclk_lvl = 1'b1;
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b1, 5000, 1'b1, 1'b1);
      cycle(1'b1, 6000, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_backpressure();
      sclk_lvl = 1'b0;
      do_reset();
      sclk_lvl = 1'b1;
      for (int i = 0; i < 12; i++) cycle(1'b1, 2048 * i - 7000, 1'b0, i < 8);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
      checks += 3;
      if (o_fill !== 4'd8)  begin errors++; $display("FAIL bp_fill: got %0d, want 8", o_fill); end
      if (o_ovf  !== 1'b1)  begin errors++; $display("FAIL bp_ovf: got %b, want 1", o_ovf); end
      if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, want 1", o_valid); end
      cycle(1'b1, 100000, 1'b0, 1'b1);
      cycle(1'b1, 200000, 1'b0, 1'b1);
      cycle(1'b1, 300000, 1'b1, 1'b1);
      checks++;
      if (o_fill !== 4'd8) begin errors++; $display("FAIL bp_rw_fill0: got %0d, want 8", o_fill); end
      cycle(1'b1, 400000, 1'b1, 1'b1);
      checks++;
      if (o_fill !== 4'd8) begin errors++; $display("FAIL bp_rw_fill1: got %0d, want 8", o_fill); end
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      checks++;
      if (o_fill !== 4'd8) begin errors++; $display("FAIL bp_rw_fill2: got %0d, want 8", o_fill); end
      drain();
   endtask

   task automatic test_random_handshake();
      logic ena;
      sclk_lvl = 1'b0;
      do_reset();
      sclk_lvl = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ena = (exp_q.size() < 6) && ($urandom_range(0, 1) == 1);
         cycle(ena, int'($urandom_range(0, 67108863)) - 33554432,
               $urandom_range(0, 2) != 0, 1'b1);
      end
      drain();
      checks++;
      if (o_ovf !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %b, want 0", o_ovf); end
   endtask

   task automatic test_reset_midstream();
      sclk_lvl = 1'b0;
      do_reset();
      run_period(30, 1'b1);
      run_period(30, 1'b1);
      drain();
      sclk_lvl = 1'b1;
      cycle(1'b1, 33554431, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 3000 * i, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
      checks += 3;
      if (o_fill !== 4'd5) begin errors++; $display("FAIL mid_fill: got %0d, want 5", o_fill); end
      if (o_lock !== 1'b1) begin errors++; $display("FAIL mid_lock: got %b, want 1", o_lock); end
      if (o_sat  !== 1'b1) begin errors++; $display("FAIL mid_sat: got %b, want 1", o_sat); end
      cycle(1'b1, 12345, 1'b0, 1'b0);
      cycle(1'b1, 23456, 1'b0, 1'b0);
      do_reset();
      checks += 5;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, want 0", o_valid); end
      if (o_fill  !== 4'd0) begin errors++; $display("FAIL mrst_fill: got %0d, want 0", o_fill); end
      if (o_lock  !== 1'b0) begin errors++; $display("FAIL mrst_lock: got %b, want 0", o_lock); end
      if (o_sat   !== 1'b0) begin errors++; $display("FAIL mrst_sat: got %b, want 0", o_sat); end
      if (o_ovf   !== 1'b0) begin errors++; $display("FAIL mrst_ovf: got %b, want 0", o_ovf); end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b0);
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL mrst_inflight%0d: got o_valid=%b, want 0", i, o_valid);
         end
      end
   endtask

   initial begin
      i_rst       = 1'b0;
      i_ena       = 1'b0;
      i_data      = '0;
      i_sclk      = 1'b0;
      i_clr_flags = 1'b0;
      i_ready     = 1'b0;
      sclk_lvl    = 1'b0;
      clr_lvl     = 1'b0;
      sclk_prev   = 1'b0;
      ph_next     = 0;
      pend        = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_rounding();
      test_saturation();
      test_lock();
      test_pending_edge();
      test_backpressure();
      test_random_handshake();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
